rv_shift_pipe: RTL and testbench



---
 rtl/rv_shift_pkg.sv | 25 ++
 rtl/rv_shift_stage.sv | 75 +++++++
 rtl/rv_shift_pipe.sv | 100 ++++++++++
 tb/tb_rv_shift_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_shift_pkg.sv
// Op encodings and barrel-level distribution helpers shared by the pipelined shifter.
package rv_shift_pkg;

  // Op field is {rot, dir, arith}
  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b110;

  function automatic int levels_per_stage(input int xlen, input int stages);
    return ($clog2(xlen) + stages - 1) / stages;
  endfunction

  // The last stages absorb the remainder, which may leave a trailing stage as a pure register.
  function automatic int stage_level_count(input int xlen, input int stages, input int s);
    int lps;
    int rem;
    lps = levels_per_stage(xlen, stages);
    rem = $clog2(xlen) - s * lps;
    if (rem <= 0) return 0;
    return (rem < lps) ? rem : lps;
  endfunction

endpackage

// File: rtl/rv_shift_stage.sv
// One pipeline stage: barrel levels FIRST..FIRST+COUNT-1 feeding a payload register; 1-cycle latency.
// Loads when empty or when down_rdy is high, otherwise holds; ROL/ROR wrap only with RV_SHIFT_ROTATE_EN.
module rv_shift_stage
  import rv_shift_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int FIRST = 0,
  parameter int COUNT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_value,
  input  logic [$clog2(XLEN)-1:0]  in_amt,
  input  logic [2:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     down_rdy,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_value,
  output logic [$clog2(XLEN)-1:0]  out_amt,
  output logic [2:0]               out_op,
  output logic [TAG_W-1:0]         out_tag
);
  localparam int SHW = $clog2(XLEN);

  typedef struct packed {
    logic [XLEN-1:0]  value;
    logic [SHW-1:0]   amt;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } payload_t;

  payload_t        q;
  logic [XLEN-1:0] nxt_value;

  function automatic logic [XLEN-1:0] shift_level(input logic [XLEN-1:0] v,
                                                  input logic [2:0] op, input int sh);
    logic [XLEN-1:0] r;
    if ((op & 3'b011) == OP_SRA)      r = $unsigned($signed(v) >>> sh);
    else if ((op & 3'b011) == OP_SRL) r = v >> sh;
    else                              r = v << sh;
`ifdef RV_SHIFT_ROTATE_EN
    if (op == OP_ROR)      r = (v >> sh) | (v << (XLEN - sh));
    else if (op == OP_ROL) r = (v << sh) | (v >> (XLEN - sh));
`endif
    return r;
  endfunction

  always_comb begin
    nxt_value = in_value;
    for (int k = 0; k < COUNT; k++) begin
      if (in_amt[FIRST + k]) nxt_value = shift_level(nxt_value, in_op, 1 << (FIRST + k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!out_valid || down_rdy) begin
      out_valid <= in_valid;
      if (in_valid) q <= '{value: nxt_value, amt: in_amt, op: in_op, tag: in_tag};
    end
  end

  assign out_value = q.value;
  assign out_amt   = q.amt;
  assign out_op    = q.op;
  assign out_tag   = q.tag;

endmodule

// File: rtl/rv_shift_pipe.sv
// Pipelined SLL/SRL/SRA shifter (ROL/ROR with RV_SHIFT_ROTATE_EN), exactly STAGES cycles accept-to-valid.
// Combinational ready chain from out_ready back to in_ready; flush empties every stage.
module rv_shift_pipe
  import rv_shift_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_imm,
  input  logic [31:0]      code_bus,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
);
  localparam int SHW = $clog2(XLEN);
  localparam int LPS = levels_per_stage(XLEN, STAGES);

  logic             stg_vld    [STAGES];
  logic             stg_dn_rdy [STAGES];
  logic [XLEN-1:0]  stg_value  [STAGES];
  logic [SHW-1:0]   stg_amt    [STAGES];
  logic [2:0]       stg_op     [STAGES];
  logic [TAG_W-1:0] stg_tag    [STAGES];
  logic [SHW-1:0]   req_amt;

  assign req_amt = in_imm ? code_bus[20 +: SHW] : rs2[SHW-1:0];

  // stg_dn_rdy[s]: whatever follows stage s will take its payload at the next edge
  always_comb begin
    stg_dn_rdy[STAGES-1] = out_ready;
    for (int s = STAGES - 2; s >= 0; s--) begin
      stg_dn_rdy[s] = !stg_vld[s+1] || stg_dn_rdy[s+1];
    end
  end

  assign in_ready = (!stg_vld[0] || stg_dn_rdy[0]) && !flush;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             src_vld;
    logic [XLEN-1:0]  src_value;
    logic [SHW-1:0]   src_amt;
    logic [2:0]       src_op;
    logic [TAG_W-1:0] src_tag;

    if (s == 0) begin : g_head
      assign src_vld   = in_valid;
      assign src_value = rs1;
      assign src_amt   = req_amt;
      assign src_op    = in_op;
      assign src_tag   = in_tag;
    end else begin : g_body
      assign src_vld   = stg_vld[s-1];
      assign src_value = stg_value[s-1];
      assign src_amt   = stg_amt[s-1];
      assign src_op    = stg_op[s-1];
      assign src_tag   = stg_tag[s-1];
    end

    rv_shift_stage #(
      .XLEN  (XLEN),
      .TAG_W (TAG_W),
      .FIRST (s * LPS),
      .COUNT (stage_level_count(XLEN, STAGES, s))
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (src_vld),
      .in_value  (src_value),
      .in_amt    (src_amt),
      .in_op     (src_op),
      .in_tag    (src_tag),
      .down_rdy  (stg_dn_rdy[s]),
      .out_valid (stg_vld[s]),
      .out_value (stg_value[s]),
      .out_amt   (stg_amt[s]),
      .out_op    (stg_op[s]),
      .out_tag   (stg_tag[s])
    );
  end

  assign out_valid = stg_vld[STAGES-1];
  assign result    = stg_value[STAGES-1];
  assign out_tag   = stg_tag[STAGES-1];

  logic unused_bits;
  assign unused_bits = ^{code_bus, rs2, stg_amt[STAGES-1], stg_op[STAGES-1]};

endmodule

// File: tb/tb_rv_shift_pipe.sv
// Scoreboard bench for rv_shift_pipe: random and directed ops checked against a behavioural model.
module tb_rv_shift_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
);
  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, in_imm, out_valid, out_ready;
  logic [2:0]       in_op;
  logic [31:0]      code_bus;
  logic [XLEN-1:0]  rs1, rs2, result;
  logic [TAG_W-1:0] in_tag, out_tag;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [2:0] ops [5];
  bit         rand_ready = 0, force_nready = 0, bp_arm = 0, bp_phase = 0, saw_nready = 0;
  int         stall_left = 0;

  rv_shift_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .code_bus(code_bus), .rs1(rs1), .rs2(rs2),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference: plain shift/rotate arithmetic on the whole word.
  function automatic int ref_amt(input logic imm, input logic [31:0] cb, input logic [XLEN-1:0] b);
    if (imm) return int'((cb >> 20) % XLEN);
    return int'(b % XLEN);
  endfunction

  function automatic logic [XLEN-1:0] ref_shift(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                input int amt);
    logic [2*XLEN-1:0] w;
    logic [XLEN-1:0]   r;
    bit                rot;
    rot = op[2];
`ifndef RV_SHIFT_ROTATE_EN
    rot = 0;
`endif
    if (rot && op[1]) begin
      w = {a, a} >> amt;
      r = w[XLEN-1:0];
    end else if (rot) begin
      w = {a, a} << amt;
      r = w[2*XLEN-1:XLEN];
    end else if (!op[1]) begin
      r = a << amt;
    end else if (op[0]) begin
      r = $signed(a) >>> amt;
    end else begin
      r = a >> amt;
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[XLEN-1:0];
  endfunction

  task automatic drive_ready();
    if (force_nready) out_ready = 1'b0;
    else if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (bp_arm && out_valid) begin
      out_ready  = 1'b0;
      stall_left = 2;
      bp_arm     = 0;
    end else out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    drive_ready();
  endtask

  task automatic send(input logic [2:0] op, input logic imm, input logic [31:0] cb,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [TAG_W-1:0] tg, input bit lat);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clk);
    in_op = op; in_imm = imm; code_bus = cb; rs1 = a; rs2 = b; in_tag = tg; in_valid = 1'b1;
    drive_ready();
    #1;
    while (!in_ready && waited < 200) begin
      if (bp_phase) saw_nready = 1;
      @(negedge clk);
      drive_ready();
      #1;
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
      in_valid = 1'b0;
    end else begin
      e.res = ref_shift(op, a, ref_amt(imm, cb, b));
      e.tag = tg;
      e.acc = cyc;
      e.lat = lat;
      exp_q.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      idle();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_flush(input bit with_valid);
    @(negedge clk);
    flush = 1'b1; in_valid = with_valid; in_op = ops[$urandom_range(0, 4)];
    rs1 = rnd(); rs2 = rnd(); in_tag = TAG_W'($urandom());
    drive_ready();
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    drive_ready();
    exp_q.delete();
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'(0));
  endtask

  // Monitor: samples just before each edge, pops on every output handshake.
  initial begin
    exp_t            e;
    bit              prev_stall;
    logic [XLEN-1:0] prev_res;
    logic [TAG_W-1:0] prev_tag;
    prev_stall = 0;
    prev_res   = '0;
    prev_tag   = '0;
    forever begin
      @(posedge clk);
      #8;
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_result", 64'(result), 64'(prev_res));
        chk("hold_tag", 64'(out_tag), 64'(prev_tag));
      end
      prev_stall = !rst && !flush && out_valid && !out_ready;
      prev_res   = result;
      prev_tag   = out_tag;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: tag %0h result %0h, no result was expected", out_tag, result);
        end else begin
          e = exp_q.pop_front();
          chk("result", 64'(result), 64'(e.res));
          chk("tag", 64'(out_tag), 64'(e.tag));
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(STAGES));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [XLEN-1:0] b;
    ops = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b110};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_imm = 1'b0;
    code_bus = '0; rs1 = '0; rs2 = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_result", 64'(result), 64'(0));
    chk("reset_out_tag", 64'(out_tag), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, each from an empty pipe so latency is exact
    send(3'b011, 1'b0, 32'h0, XLEN'(32'h8000_00F0), XLEN'(4), TAG_W'(7), 1); drain();
    send(3'b000, 1'b1, 32'd31 << 20, XLEN'(3), rnd(), TAG_W'(9), 1); drain();
    send(3'b010, 1'b0, 32'h0, XLEN'(32'hF000_0000), XLEN'(32'hFFFF_FFE4), TAG_W'(10), 1); drain();
    send(3'b110, 1'b0, 32'h0, XLEN'(1), XLEN'(1), TAG_W'(11), 1); drain();
    send(3'b100, 1'b0, 32'h0, XLEN'(32'h8000_0001), XLEN'(4), TAG_W'(12), 1); drain();
    for (int i = 0; i < 5; i++) begin
      b = rnd();
      b[$clog2(XLEN)-1:0] = '0;
      send(ops[i], 1'b0, 32'h0, rnd(), b, TAG_W'(i), 1);
    end
    drain();

    // Back-to-back burst with a 3-cycle output stall once results appear
    bp_arm = 1; bp_phase = 1; saw_nready = 0;
    for (int t = 0; t < 6; t++) send(ops[$urandom_range(0, 4)], 1'b0, $urandom(), rnd(), rnd(), TAG_W'(t), 0);
    bp_phase = 0; bp_arm = 0;
    drain();
    chk("bp_in_ready_drop", 64'(saw_nready), 64'(1));

    // Flush with ops in flight and a request offered in the flush cycle
    force_nready = 1;
    send(3'b000, 1'b0, 32'h0, rnd(), rnd(), TAG_W'(1), 0);
    if (STAGES > 1) send(3'b010, 1'b0, 32'h0, rnd(), rnd(), TAG_W'(2), 0);
    do_flush(1);
    force_nready = 0;
    send(3'b011, 1'b0, 32'h0, rnd(), rnd(), TAG_W'(3), 1);
    drain();

    // Reset with the pipe holding data
    force_nready = 1;
    send(3'b010, 1'b0, 32'h0, rnd() | XLEN'(1), XLEN'(1), TAG_W'(4), 0);
    if (STAGES > 1) send(3'b000, 1'b0, 32'h0, rnd() | XLEN'(1), XLEN'(1), TAG_W'(5), 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    drive_ready();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    drive_ready();
    exp_q.delete();
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_result", 64'(result), 64'(0));
    chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
    force_nready = 0;

    // Random traffic with random backpressure and occasional flushes
    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) do_flush(1'($urandom_range(0, 1)));
      else if ($urandom_range(0, 3) == 0) idle();
      else begin
        b = ($urandom_range(0, 1) != 0) ? rnd() : XLEN'($urandom_range(0, XLEN - 1));
        send(ops[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), $urandom(), rnd(), b,
             TAG_W'($urandom()), 0);
      end
    end
    rand_ready = 0;
    drain();
    repeat (STAGES + 2) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
